// File: rtl/p2s_serializer_ml.sv
// p2s_serializer_ml: parallel-to-serial converter.
// Takes DATA_W-bit words over a valid/ready handshake and emits them LANES
// bits per clock with svalid/slast framing. An optional gap of GAP_CYCLES
// idle cycles separates consecutive words.
// Optional feature: define P2S_PARITY_EN to append one per-lane even-parity
// beat after the data beats of every word.
module p2s_serializer_ml #(
  parameter int DATA_W     = 8,
  parameter int LANES      = 1,
  parameter int MSB_FIRST  = 1,
  parameter int GAP_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] pdata,
  input  logic              pvalid,
  output logic              pready,
  output logic [LANES-1:0]  sdata,
  output logic              svalid,
  output logic              slast,
  output logic              busy
);

  localparam int BEATS = DATA_W / LANES;
`ifdef P2S_PARITY_EN
  localparam int TOTAL = BEATS + 1;
`else
  localparam int TOTAL = BEATS;
`endif
  localparam int              CNT_W    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TOTAL - 1);
  localparam logic [3:0]       GAP_LAST = 4'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  shreg_q, shreg_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [3:0]         gap_q, gap_d;
  logic               pready_q, pready_d;
  logic [LANES-1:0]   sdata_q, sdata_d;
  logic               svalid_q, svalid_d;
  logic               slast_q, slast_d;
  logic               busy_q, busy_d;
  logic               xfer;
`ifdef P2S_PARITY_EN
  logic [LANES-1:0]   parity_q, parity_d;

  // Even parity per lane: XOR of every slice the word will put on the lines.
  function automatic logic [LANES-1:0] lane_parity(input logic [DATA_W-1:0] w);
    logic [LANES-1:0] p;
    p = '0;
    for (int k = 0; k < BEATS; k++) p ^= w[k*LANES +: LANES];
    return p;
  endfunction
`endif

  // Next-state logic; outputs are precomputed from next state so they leave flops.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    count_d = count_q;
    gap_d   = gap_q;
`ifdef P2S_PARITY_EN
    parity_d = parity_q;
`endif
    xfer = pvalid && pready_q;

    case (state_q)
      IDLE: begin
        if (xfer) begin
          state_d = SHIFT;
          shreg_d = pdata;
          count_d = '0;
`ifdef P2S_PARITY_EN
          parity_d = lane_parity(pdata);
`endif
        end
      end
      SHIFT: begin
        if (count_q == LAST_CNT) begin
          if (GAP_CYCLES == 0) begin
            if (xfer) begin
              shreg_d = pdata;
              count_d = '0;
`ifdef P2S_PARITY_EN
              parity_d = lane_parity(pdata);
`endif
            end else begin
              state_d = IDLE;
            end
          end else begin
            state_d = GAP;
            gap_d   = '0;
          end
        end else begin
          count_d = count_q + CNT_W'(1);
          shreg_d = (MSB_FIRST != 0) ? (shreg_q << LANES) : (shreg_q >> LANES);
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) state_d = IDLE;
        else                   gap_d   = gap_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase

    svalid_d = (state_d == SHIFT);
    slast_d  = svalid_d && (count_d == LAST_CNT);
    busy_d   = (state_d != IDLE);
    pready_d = (state_d == IDLE) || ((GAP_CYCLES == 0) && slast_d);
    sdata_d  = '0;
    if (svalid_d) begin
      sdata_d = (MSB_FIRST != 0) ? shreg_d[DATA_W-1 -: LANES] : shreg_d[LANES-1:0];
`ifdef P2S_PARITY_EN
      if (count_d == CNT_W'(BEATS)) sdata_d = parity_d;
`endif
    end
  end

  // State, datapath and output registers; reset drops any word in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      count_q  <= '0;
      gap_q    <= '0;
      pready_q <= 1'b1;
      sdata_q  <= '0;
      svalid_q <= 1'b0;
      slast_q  <= 1'b0;
      busy_q   <= 1'b0;
`ifdef P2S_PARITY_EN
      parity_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      count_q  <= count_d;
      gap_q    <= gap_d;
      pready_q <= pready_d;
      sdata_q  <= sdata_d;
      svalid_q <= svalid_d;
      slast_q  <= slast_d;
      busy_q   <= busy_d;
`ifdef P2S_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign pready = pready_q;
  assign sdata  = sdata_q;
  assign svalid = svalid_q;
  assign slast  = slast_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_p2s_serializer_ml.sv
// Testbench for p2s_serializer_ml: three instances (MSB-first 1 lane,
// LSB-first 2 lanes, MSB-first 1 lane with a 2-cycle gap) checked every
// cycle against a queue-of-beats model, plus literal line patterns.
`timescale 1ns/1ps
module tb_p2s_serializer_ml;

   localparam int N = 3;
`ifdef P2S_PARITY_EN
   localparam int EXTRA = 1;
`else
   localparam int EXTRA = 0;
`endif

   logic clk;
   logic rst_n;
   logic [7:0] pdata [N];
   logic pvalid [N];
   logic pready [N];
   logic svalid [N];
   logic slast [N];
   logic busy [N];
   logic [0:0] sdata0;
   logic [1:0] sdata1;
   logic [0:0] sdata2;

   int testsRun;
   int testsFailed;

   // Model state: pending beats per instance and remaining gap cycles
   int mBuf [N][32];
   int mHead [N];
   int mCnt [N];
   int mGap [N];

   // Words waiting to be offered on each instance's handshake
   logic [7:0] sendBuf [N][8];
   int sendCnt [N];
   bit xferNow [N];

   // Observed line history for the literal pattern checks
   logic [31:0] obs0Bits;
   int obs0Len, obs0LastPos, obs0LastCnt, obs0Run, obs0MaxRun;
   logic [31:0] obs1Bits;
   int obs1Len, obs1LastPos;
   int gapRun, gapArmed, gapMeasured;

   p2s_serializer_ml #(.DATA_W(8), .LANES(1), .MSB_FIRST(1), .GAP_CYCLES(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .pdata(pdata[0]), .pvalid(pvalid[0]), .pready(pready[0]),
      .sdata(sdata0), .svalid(svalid[0]), .slast(slast[0]), .busy(busy[0]));

   p2s_serializer_ml #(.DATA_W(8), .LANES(2), .MSB_FIRST(0), .GAP_CYCLES(0)) dut1 (
      .clk(clk), .rst_n(rst_n), .pdata(pdata[1]), .pvalid(pvalid[1]), .pready(pready[1]),
      .sdata(sdata1), .svalid(svalid[1]), .slast(slast[1]), .busy(busy[1]));

   p2s_serializer_ml #(.DATA_W(8), .LANES(1), .MSB_FIRST(1), .GAP_CYCLES(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .pdata(pdata[2]), .pvalid(pvalid[2]), .pready(pready[2]),
      .sdata(sdata2), .svalid(svalid[2]), .slast(slast[2]), .busy(busy[2]));

   // Free-running 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int laneOf(input int i);
      return (i == 1) ? 2 : 1;
   endfunction

   function automatic int msbOf(input int i);
      return (i == 1) ? 0 : 1;
   endfunction

   function automatic int gapOf(input int i);
      return (i == 2) ? 2 : 0;
   endfunction

   function automatic logic [1:0] sdataOf(input int i);
      case (i)
         0: return {1'b0, sdata0};
         1: return sdata1;
         default: return {1'b0, sdata2};
      endcase
   endfunction

   function automatic void modelReset();
      for (int i = 0; i < N; i++) begin
         mHead[i] = 0;
         mCnt[i] = 0;
         mGap[i] = 0;
      end
   endfunction

   // A word may enter when nothing is pending, or on the final beat of a gapless word
   function automatic bit modelPready(input int i);
      return (mCnt[i] == 0 && mGap[i] == 0) || (mCnt[i] == 1 && gapOf(i) == 0);
   endfunction

   // Cut a word into its line slices by plain shifting and append them
   function automatic void modelPush(input int i, input logic [7:0] w);
      int lanes, beats, mask, sh, v, par;
      lanes = laneOf(i);
      beats = 8 / lanes;
      mask = (1 << lanes) - 1;
      par = 0;
      for (int k = 0; k < beats; k++) begin
         sh = (msbOf(i) != 0) ? (8 - (k + 1) * lanes) : (k * lanes);
         v = (int'(w) >> sh) & mask;
         par = par ^ v;
         mBuf[i][(mHead[i] + mCnt[i]) % 32] = v;
         mCnt[i]++;
      end
      if (EXTRA != 0) begin
         mBuf[i][(mHead[i] + mCnt[i]) % 32] = par;
         mCnt[i]++;
      end
   endfunction

   // One clock edge: consume a beat or a gap cycle, then take any new word
   function automatic void modelStep(input int i, input bit xfer, input logic [7:0] w);
      if (mCnt[i] > 0) begin
         mHead[i] = (mHead[i] + 1) % 32;
         mCnt[i]--;
         if (mCnt[i] == 0 && gapOf(i) > 0) mGap[i] = gapOf(i);
      end else if (mGap[i] > 0) begin
         mGap[i]--;
      end
      if (xfer) modelPush(i, w);
   endfunction

   // Expected {pready, busy, svalid, slast, sdata[1:0]}
   function automatic logic [5:0] expOut(input int i);
      logic [5:0] e;
      if (mCnt[i] > 0) e = {modelPready(i), 1'b1, 1'b1, (mCnt[i] == 1), 2'(mBuf[i][mHead[i]])};
      else             e = {modelPready(i), (mGap[i] > 0), 1'b0, 1'b0, 2'b00};
      return e;
   endfunction

   function automatic logic [5:0] actOut(input int i);
      return {pready[i], busy[i], svalid[i], slast[i], sdataOf(i)};
   endfunction

   task automatic checkEq(input string name, input int got, input int want);
      testsRun++;
      if (got != want) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
      end
   endtask

   task automatic clearObs();
      obs0Bits = '0; obs0Len = 0; obs0LastPos = -1; obs0LastCnt = 0; obs0Run = 0; obs0MaxRun = 0;
      obs1Bits = '0; obs1Len = 0; obs1LastPos = -1;
      gapRun = 0; gapArmed = 0; gapMeasured = -1;
   endtask

   task automatic queueWord(input int i, input logic [7:0] w);
      sendBuf[i][sendCnt[i]] = w;
      sendCnt[i]++;
   endtask

   // Per-cycle compare of every instance against the model, plus line history capture
   task automatic checkOutput();
      for (int i = 0; i < N; i++)
         checkEq($sformatf("cycle out%0d t=%0t", i, $time), int'(actOut(i)), int'(expOut(i)));
      if (svalid[0]) begin
         obs0Bits = {obs0Bits[30:0], sdata0};
         if (slast[0]) begin
            obs0LastPos = obs0Len;
            obs0LastCnt++;
         end
         obs0Len++;
         obs0Run++;
         if (obs0Run > obs0MaxRun) obs0MaxRun = obs0Run;
      end else begin
         obs0Run = 0;
      end
      if (svalid[1]) begin
         obs1Bits = {obs1Bits[29:0], sdata1};
         if (slast[1]) obs1LastPos = obs1Len;
         obs1Len++;
      end
      if (slast[2]) begin
         gapArmed = 1;
         gapRun = 0;
      end else if (gapArmed != 0 && svalid[2]) begin
         if (gapMeasured < 0) gapMeasured = gapRun;
         gapArmed = 0;
      end else if (gapArmed != 0 && !svalid[2] && !pready[2]) begin
         gapRun++;
      end
   endtask

   // One cycle: check at the falling edge, drive inputs, step the model at the rising edge
   task automatic applyStimulus(input bit randomDrop);
      @(negedge clk);
      checkOutput();
      for (int i = 0; i < N; i++) begin
         if (sendCnt[i] > 0 && (!randomDrop || $urandom_range(3) != 0)) begin
            pvalid[i] = 1'b1;
            pdata[i] = sendBuf[i][0];
         end else begin
            pvalid[i] = 1'b0;
            pdata[i] = 8'($urandom);
         end
         xferNow[i] = pvalid[i] && modelPready(i);
      end
      @(posedge clk);
      for (int i = 0; i < N; i++) begin
         modelStep(i, xferNow[i], pdata[i]);
         if (xferNow[i]) begin
            for (int j = 0; j < 7; j++) sendBuf[i][j] = sendBuf[i][j + 1];
            sendCnt[i]--;
         end
      end
   endtask

   // Main sequence: reset, directed patterns, mid-word reset, then random traffic
   initial begin
      testsRun = 0;
      testsFailed = 0;
      rst_n = 1'b1;
      for (int i = 0; i < N; i++) begin
         pvalid[i] = 1'b0;
         pdata[i] = 8'h00;
         sendCnt[i] = 0;
      end
      modelReset();
      clearObs();
      #1 rst_n = 1'b0;
      #11;
      for (int i = 0; i < N; i++)
         checkEq($sformatf("reset out%0d", i), int'(actOut(i)), 6'b100000);
      rst_n = 1'b1;

      // Single words: 0xA5 MSB-first on one lane, 0xB4 LSB-first on two lanes
      queueWord(0, 8'hA5);
      queueWord(1, 8'hB4);
      repeat (14) applyStimulus(1'b0);
      checkEq("a5 length", obs0Len, 8 + EXTRA);
      checkEq("a5 bits", int'(obs0Bits), (EXTRA != 0) ? 32'h14A : 32'hA5);
      checkEq("a5 slast pos", obs0LastPos, 7 + EXTRA);
      checkEq("a5 slast count", obs0LastCnt, 1);
      checkEq("b4 length", obs1Len, 4 + EXTRA);
      checkEq("b4 bits", int'(obs1Bits), (EXTRA != 0) ? 32'h078 : 32'h1E);
      checkEq("b4 slast pos", obs1LastPos, 3 + EXTRA);

      // Back-to-back 0x0F, 0xF0 with pvalid held; the gapped instance gets the same pair
      clearObs();
      queueWord(0, 8'h0F);
      queueWord(0, 8'hF0);
      queueWord(2, 8'h0F);
      queueWord(2, 8'hF0);
      repeat (34) applyStimulus(1'b0);
      checkEq("b2b length", obs0Len, 16 + 2 * EXTRA);
      checkEq("b2b bits", int'(obs0Bits), (EXTRA != 0) ? 32'h3DE0 : 32'h0FF0);
      checkEq("b2b contiguous run", obs0MaxRun, 16 + 2 * EXTRA);
      checkEq("b2b slast count", obs0LastCnt, 2);
      checkEq("gap cycles", gapMeasured, 2);

      // Reset during beat 3 of 0xFF, then 0x81 must come out cleanly
      queueWord(0, 8'hFF);
      repeat (4) applyStimulus(1'b0);
      checkEq("pre-reset svalid", int'(svalid[0]), 1);
      #2 rst_n = 1'b0;
      #1;
      for (int i = 0; i < N; i++)
         checkEq($sformatf("mid-word reset out%0d", i), int'(actOut(i)), 6'b100000);
      modelReset();
      @(negedge clk);
      rst_n = 1'b1;
      clearObs();
      queueWord(0, 8'h81);
      repeat (12) applyStimulus(1'b0);
      checkEq("81 length", obs0Len, 8 + EXTRA);
      checkEq("81 bits", int'(obs0Bits), (EXTRA != 0) ? 32'h102 : 32'h81);
      checkEq("81 slast pos", obs0LastPos, 7 + EXTRA);

      // 0x07 has odd weight, so the parity beat (when present) is 1
      clearObs();
      queueWord(0, 8'h07);
      repeat (12) applyStimulus(1'b0);
      checkEq("07 bits", int'(obs0Bits), (EXTRA != 0) ? 32'h00F : 32'h07);
      checkEq("07 slast pos", obs0LastPos, 7 + EXTRA);

      // Random traffic with pvalid dropping at random
      repeat (900) begin
         for (int i = 0; i < N; i++)
            if (sendCnt[i] < 2 && $urandom_range(2) != 0) queueWord(i, 8'($urandom));
         applyStimulus(1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
